// File: rtl/data_mem_responder_pkg.sv
// ----------------------------------------------------------------------------
// data_mem_responder_pkg
//   Shared types and constants for the data-memory responder.
//   - state_e   : responder FSM states
//   - op_e      : operation latched at grant time
//   - LAT_CNT_W : width of the access-latency down-counter
//   - latency_load() : value loaded into the counter on a grant
// ----------------------------------------------------------------------------
package data_mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2,
        RELEASE = 2'd3
    } state_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

    localparam int LAT_CNT_W = 4;

    // The counter runs from latency-1 down to 0 inclusive, so ACCESS lasts
    // exactly `latency` cycles.
    function automatic logic [LAT_CNT_W-1:0] latency_load(input int latency);
        return LAT_CNT_W'(latency - 1);
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// ----------------------------------------------------------------------------
// data_mem_responder_if
//   Per-thread data-memory channel bundle between the LSUs (master) and the
//   memory responder (slave). Every field is a packed vector with one lane
//   per channel.
//   read_valid/read_address        : read request, address held with valid
//   read_ready/read_data           : read complete, data valid while ready
//   write_valid/write_address/data : write request
//   write_ready                    : write committed
// ----------------------------------------------------------------------------
interface data_mem_responder_if #(
    parameter int CHANNELS  = 4,
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8
);

    logic [CHANNELS-1:0]                read_valid;
    logic [CHANNELS-1:0][ADDR_BITS-1:0] read_address;
    logic [CHANNELS-1:0]                read_ready;
    logic [CHANNELS-1:0][DATA_BITS-1:0] read_data;

    logic [CHANNELS-1:0]                write_valid;
    logic [CHANNELS-1:0][ADDR_BITS-1:0] write_address;
    logic [CHANNELS-1:0][DATA_BITS-1:0] write_data;
    logic [CHANNELS-1:0]                write_ready;

    modport master (
        output read_valid, read_address,
        output write_valid, write_address, write_data,
        input  read_ready, read_data, write_ready
    );

    modport slave (
        input  read_valid, read_address,
        input  write_valid, write_address, write_data,
        output read_ready, read_data, write_ready
    );

endinterface

// File: rtl/data_mem_responder_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin picker. Grants the first requesting index at or
//   after `pointer`, wrapping modulo N. The pointer register is owned by the
//   parent so that it only advances when a grant is actually taken.
//   req         : per-requester request bits
//   pointer     : highest-priority index this cycle
//   grant_valid : at least one requester is active
//   grant_idx   : chosen requester (0 when grant_valid is low)
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] pointer,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int off = 0; off < N; off++) begin
            cand = IDX_W'((int'(pointer) + off) % N);
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// ----------------------------------------------------------------------------
// data_mem_responder
//   Responder end of the per-thread data-memory channels. Requests from all
//   channels are arbitrated round-robin onto one single-port array; one
//   request is in flight at a time. Each access takes MEM_LATENCY cycles and
//   completes with a 4-phase handshake (ready held while the requester holds
//   valid, then one RELEASE cycle).
//
//   Ports
//     clk   : clock
//     reset : asynchronous, active-low reset
//     bus   : channel bundle (slave side), see data_mem_responder_if
//     busy  : FSM is not IDLE
//
//   Parameters
//     ADDR_BITS   : address width, array depth 2**ADDR_BITS
//     DATA_BITS   : data word width
//     CHANNELS    : number of requester channels
//     MEM_LATENCY : array access cycles, 1..15
// ----------------------------------------------------------------------------
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int ADDR_BITS   = 8,
    parameter int DATA_BITS   = 8,
    parameter int CHANNELS    = 4,
    parameter int MEM_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    data_mem_responder_if.slave   bus,
    output logic                  busy
);

    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int DEPTH = 2 ** ADDR_BITS;

    // FSM and control state
    state_e                state_q, state_d;
    logic [LAT_CNT_W-1:0]  cnt_q, cnt_d;
    logic [CH_W-1:0]       ptr_q, ptr_d;
    logic [CH_W-1:0]       chan_q;
    op_e                   op_q;

    // Request payload captured at grant time
    logic [ADDR_BITS-1:0]  addr_q;
    logic [DATA_BITS-1:0]  wdata_q;

    // Arbiter
    logic [CHANNELS-1:0]   req;
    logic                  grant_valid;
    logic [CH_W-1:0]       grant_idx;

    // Strobes from the next-state logic
    logic                  accept;
    logic                  mem_we;
    logic                  rd_capture;
    logic                  op_valid;
    logic [CHANNELS-1:0]   read_ready_d;
    logic [CHANNELS-1:0]   write_ready_d;

    // Array and returned data
    logic [DATA_BITS-1:0]                mem [DEPTH];
    logic [DATA_BITS-1:0]                mem_rdata;
    logic [CHANNELS-1:0][DATA_BITS-1:0]  read_data_q;

    assign req = bus.read_valid | bus.write_valid;

    rr_arbiter #(.N(CHANNELS)) u_arb (
        .req         (req),
        .pointer     (ptr_q),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // Valid of the operation currently being served; a channel that asked for
    // both ops is served as a read, so the write request keeps it requesting.
    assign op_valid = (op_q == OP_READ) ? bus.read_valid[chan_q]
                                        : bus.write_valid[chan_q];

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ptr_d         = ptr_q;
        accept        = 1'b0;
        mem_we        = 1'b0;
        rd_capture    = 1'b0;
        read_ready_d  = '0;
        write_ready_d = '0;

        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    accept  = 1'b1;
                    ptr_d   = (grant_idx == CH_W'(CHANNELS - 1)) ? '0
                                                                 : grant_idx + 1'b1;
                    cnt_d   = latency_load(MEM_LATENCY);
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    if (op_q == OP_WRITE) begin
                        mem_we = 1'b1;
                    end else begin
                        rd_capture = 1'b1;
                    end
                    state_d = RESPOND;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESPOND: begin
                if (op_q == OP_READ) begin
                    read_ready_d[chan_q] = 1'b1;
                end else begin
                    write_ready_d[chan_q] = 1'b1;
                end
                // A valid already dropped still gets exactly one ready cycle.
                if (!op_valid) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // --- control registers -------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            chan_q  <= '0;
            op_q    <= OP_READ;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            if (accept) begin
                chan_q <= grant_idx;
                op_q   <= bus.read_valid[grant_idx] ? OP_READ : OP_WRITE;
            end
        end
    end

    // --- request payload capture (data only, no reset) ---------------------
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= bus.read_valid[grant_idx] ? bus.read_address[grant_idx]
                                                 : bus.write_address[grant_idx];
            wdata_q <= bus.write_data[grant_idx];
        end
    end

    // --- single-port array -------------------------------------------------
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_q] <= wdata_q;
        end
    end

    assign mem_rdata = mem[addr_q];

    // --- per-channel read result; holds until the next read on that channel
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            read_data_q <= '0;
        end else if (rd_capture) begin
            read_data_q[chan_q] <= mem_rdata;
        end
    end

    assign bus.read_ready  = read_ready_d;
    assign bus.write_ready = write_ready_d;
    assign bus.read_data   = read_data_q;
    assign busy            = (state_q != IDLE);

endmodule
